vec_chunk_sequencer: RTL

VEC_CHUNK_SEQUENCER -- requirements
Module: vec_chunk_sequencer

---
 rtl/vec_chunk_sequencer_if.sv | 68 ++++++
 rtl/vec_chunk_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_chunk_sequencer_if.sv
// Bundles the start/status, source-read, elementwise-unit and destination-write
// signals of the vector chunk sequencer. The sequencer uses the master view.
// The surrounding buffers and the elementwise unit use the slave view.
interface vec_chunk_sequencer_if #(
  parameter int WorkingRegs = 4,
  parameter int CW          = 4
);

  // Pass control and status
  logic                     start_in;
  logic                     busy_out;
  logic                     done_out;
  logic                     overflow_out;

  // Source buffer read port
  logic                     src_rd_en;
  logic [CW-1:0]            src_rd_addr;
  logic [WorkingRegs*8-1:0] src_rd_data;

  // Elementwise unit issue and return
  logic                     op_valid_out;
  logic [WorkingRegs*8-1:0] op_data_out;
  logic                     op_valid_in;
  logic [WorkingRegs*8-1:0] op_data_in;

  // Destination buffer write port
  logic                     dst_wr_en;
  logic [CW-1:0]            dst_wr_addr;
  logic [WorkingRegs*8-1:0] dst_wr_data;
  logic                     dst_ready_in;

  modport master (
    input  start_in,
    input  src_rd_data,
    input  op_valid_in,
    input  op_data_in,
    input  dst_ready_in,
    output busy_out,
    output done_out,
    output overflow_out,
    output src_rd_en,
    output src_rd_addr,
    output op_valid_out,
    output op_data_out,
    output dst_wr_en,
    output dst_wr_addr,
    output dst_wr_data
  );

  modport slave (
    output start_in,
    output src_rd_data,
    output op_valid_in,
    output op_data_in,
    output dst_ready_in,
    input  busy_out,
    input  done_out,
    input  overflow_out,
    input  src_rd_en,
    input  src_rd_addr,
    input  op_valid_out,
    input  op_data_out,
    input  dst_wr_en,
    input  dst_wr_addr,
    input  dst_wr_data
  );

endinterface

// File: rtl/vec_chunk_sequencer.sv
// Streams one vector, chunk by chunk, from a source buffer through an external
// elementwise unit and into a destination buffer. Reads are credit-limited so
// that every in-flight result is guaranteed a slot in the local result FIFO.
module vec_chunk_sequencer #(
  parameter int InVecLength = 64,
  parameter int WorkingRegs = 4,
  parameter int Credits     = 4
) (
  input logic clk_in,
  input logic rst_in,
  vec_chunk_sequencer_if.master bus
);

  localparam int NumChunks = InVecLength / WorkingRegs;
  localparam int CW        = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int DW        = WorkingRegs * 8;
  localparam int OW        = $clog2(Credits + 1);
  localparam int PW        = (Credits > 1) ? $clog2(Credits) : 1;

  localparam logic [CW-1:0] LastIdx   = CW'(NumChunks - 1);
  localparam logic [OW-1:0] CreditMax = OW'(Credits);
  localparam logic [PW-1:0] PtrLast   = PW'(Credits - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic            busy;
  logic            done;
  logic            overflow;

  logic [CW-1:0]   rd_idx;
  logic [CW-1:0]   wr_idx;
  logic [OW-1:0]   outstanding;

  // Read strobe delayed by the source buffer's one-cycle read latency
  logic            vld_p1;

  // Result FIFO: storage is data only, pointers and fill level are control
  logic [DW-1:0]   fifo_mem [Credits];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [OW-1:0]   fill;

  logic            active;
  logic            start_pass;
  logic            rd_fire;
  logic            wr_fire;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            drop;

  // Circular pointer advance that also works for non-power-of-two depths
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PtrLast) ? '0 : p + PW'(1);
  endfunction

  // Results are only meaningful while a pass is running; anything that shows
  // up in IDLE or DONE belongs to an abandoned pass and is ignored.
  assign active     = (state == ISSUE) || (state == DRAIN);
  assign start_pass = (state == IDLE) && bus.start_in;

  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == CreditMax);

  assign rd_fire    = (state == ISSUE) && (outstanding < CreditMax);
  assign wr_fire    = active && !fifo_empty && bus.dst_ready_in;

  // A full FIFO can still take a result in the same cycle the head leaves.
  assign push       = active && bus.op_valid_in && (!fifo_full || wr_fire);
  assign drop       = active && bus.op_valid_in && fifo_full && !wr_fire;

  assign bus.src_rd_en    = rd_fire;
  assign bus.src_rd_addr  = rd_idx;
  assign bus.op_valid_out = vld_p1;
  assign bus.op_data_out  = bus.src_rd_data;
  assign bus.dst_wr_en    = wr_fire;
  assign bus.dst_wr_addr  = wr_idx;
  assign bus.dst_wr_data  = fifo_mem[head];
  assign bus.busy_out     = busy;
  assign bus.done_out     = done;
  assign bus.overflow_out = overflow;

  // Pass state machine with registered busy/done status
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            state <= ISSUE;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (rd_fire && (rd_idx == LastIdx)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (wr_fire && (wr_idx == LastIdx)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Chunk indices and credit accounting; indices park on the last chunk
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_idx      <= '0;
      wr_idx      <= '0;
      outstanding <= '0;
    end else if (start_pass) begin
      rd_idx      <= '0;
      wr_idx      <= '0;
      outstanding <= '0;
    end else begin
      if (rd_fire && (rd_idx != LastIdx)) begin
        rd_idx <= rd_idx + CW'(1);
      end
      if (wr_fire && (wr_idx != LastIdx)) begin
        wr_idx <= wr_idx + CW'(1);
      end
      case ({rd_fire, wr_fire})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Stage p0 -> p1: issue valid follows the read strobe by one cycle
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_fire;
    end
  end

  // Result FIFO pointers and fill level, flushed at the start of every pass
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head <= '0;
      tail <= '0;
      fill <= '0;
    end else if (start_pass) begin
      head <= '0;
      tail <= '0;
      fill <= '0;
    end else begin
      if (push) begin
        tail <= ptr_next(tail);
      end
      if (wr_fire) begin
        head <= ptr_next(head);
      end
      case ({push, wr_fire})
        2'b10:   fill <= fill + OW'(1);
        2'b01:   fill <= fill - OW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Result FIFO storage, written on accepted pushes only
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[tail] <= bus.op_data_in;
    end
  end

  // Sticky protocol-error flag for results dropped on a full FIFO
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule
